// File: rtl/axis_throughput_monitor.sv
// -----------------------------------------------------------------------------
// axis_throughput_monitor
//
// Passive multi-channel AXI4-Stream throughput monitor. Per channel it counts
// transferred bits (8 x popcount(tkeep) per beat) and packets (tlast beats)
// over a WINDOW_CYCLES measurement window. At each window boundary it publishes
// registered results, updates a peak-hold register and pulses window_done.
// Counters saturate at all-ones; a saturating bit add sets a sticky flag.
//
// Ports
//   clk            sole clock
//   reset_n        asynchronous assert, synchronously released active-low reset
//   enable         1 = measure, 0 = timer and accumulators held at zero
//   clear          one-cycle clear of timer, accumulators, peaks and sat flags
//   s_tvalid       per-channel tvalid (bit i = channel i), observed only
//   s_tready       per-channel tready, observed only
//   s_tkeep        per-channel tkeep, channel i at [i*DATA_WIDTH/8 +: DATA_WIDTH/8]
//   s_tlast        per-channel tlast
//   bitrate_out    bits transferred in the last completed window, per channel
//   pkt_count_out  tlast beats in the last completed window, per channel
//   peak_out       largest bitrate_out since reset or clear, per channel
//   sat_flag       sticky bit-accumulator saturation flag, per channel
//   window_done    one-cycle pulse coincident with a result update
// -----------------------------------------------------------------------------
module axis_throughput_monitor #(
    parameter int NUM_CH        = 4,
    parameter int DATA_WIDTH    = 256,
    parameter int COUNTER_WIDTH = 32,
    parameter int WINDOW_CYCLES = 200
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            enable,
    input  logic                            clear,
    input  logic [NUM_CH-1:0]               s_tvalid,
    input  logic [NUM_CH-1:0]               s_tready,
    input  logic [NUM_CH*DATA_WIDTH/8-1:0]  s_tkeep,
    input  logic [NUM_CH-1:0]               s_tlast,
    output logic [NUM_CH*COUNTER_WIDTH-1:0] bitrate_out,
    output logic [NUM_CH*COUNTER_WIDTH-1:0] pkt_count_out,
    output logic [NUM_CH*COUNTER_WIDTH-1:0] peak_out,
    output logic [NUM_CH-1:0]               sat_flag,
    output logic                            window_done
);

    localparam int KEEP_W  = DATA_WIDTH / 8;
    localparam int TIMER_W = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX    = '1;
    localparam logic [TIMER_W-1:0]       TIMER_LAST = TIMER_W'(WINDOW_CYCLES - 1);

    // Bits carried by one beat: 8 x number of valid bytes. One extra bit of
    // headroom lets the accumulator add detect overflow from the carry.
    function automatic logic [COUNTER_WIDTH:0] beat_bits(input logic [KEEP_W-1:0] keep);
        logic [COUNTER_WIDTH:0] n;
        n = '0;
        for (int b = 0; b < KEEP_W; b++) begin
            n = n + (COUNTER_WIDTH + 1)'(keep[b]);
        end
        return n << 3;
    endfunction

    // ---------------------------------------------------------------------
    // Reset synchronizer: assertion reaches every flop immediately, release
    // is aligned to clk so no flop sees reset_n rise near an edge.
    // ---------------------------------------------------------------------
    logic [1:0] rst_sync_q;
    logic       rst_n;

    // NOTE: sequential state is always written with non-blocking assignments
    // so every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= 2'b00;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    // ---------------------------------------------------------------------
    // Shared window timer
    // ---------------------------------------------------------------------
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               window_done_q, window_done_d;
    logic               terminal;

    // clear beats the terminal cycle: no publish, no pulse.
    assign terminal = enable && !clear && (timer_q == TIMER_LAST);

    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        timer_d       = '0;
        window_done_d = terminal;
        if (enable && !clear && (timer_q != TIMER_LAST)) begin
            timer_d = timer_q + TIMER_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q       <= '0;
            window_done_q <= 1'b0;
        end else begin
            timer_q       <= timer_d;
            window_done_q <= window_done_d;
        end
    end
    assign window_done = window_done_q;

    // ---------------------------------------------------------------------
    // Per-channel accumulators and results; channels share only the timer.
    // ---------------------------------------------------------------------
    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic                     beat, last_beat, bits_ovf;
        logic [COUNTER_WIDTH:0]   weight, bits_sum;
        logic [COUNTER_WIDTH-1:0] bits_new, pkts_new;

        logic [COUNTER_WIDTH-1:0] acc_bits_q, acc_bits_d;
        logic [COUNTER_WIDTH-1:0] acc_pkts_q, acc_pkts_d;
        logic [COUNTER_WIDTH-1:0] bitrate_q,  bitrate_d;
        logic [COUNTER_WIDTH-1:0] pkt_cnt_q,  pkt_cnt_d;
        logic [COUNTER_WIDTH-1:0] peak_q,     peak_d;
        logic                     sat_q,      sat_d;

        assign beat      = s_tvalid[ch] & s_tready[ch];
        assign last_beat = beat & s_tlast[ch];
        assign weight    = beat ? beat_bits(s_tkeep[ch*KEEP_W +: KEEP_W]) : '0;
        assign bits_sum  = {1'b0, acc_bits_q} + weight;
        assign bits_ovf  = bits_sum[COUNTER_WIDTH];
        assign bits_new  = bits_ovf ? CNT_MAX : bits_sum[COUNTER_WIDTH-1:0];
        assign pkts_new  = (last_beat && (acc_pkts_q != CNT_MAX))
                           ? acc_pkts_q + COUNTER_WIDTH'(1) : acc_pkts_q;

        always_comb begin
            acc_bits_d = acc_bits_q;
            acc_pkts_d = acc_pkts_q;
            bitrate_d  = bitrate_q;
            pkt_cnt_d  = pkt_cnt_q;
            peak_d     = peak_q;
            sat_d      = sat_q;
            if (clear) begin
                acc_bits_d = '0;
                acc_pkts_d = '0;
                peak_d     = '0;
                sat_d      = 1'b0;
            end else if (!enable) begin
                // Partial window is discarded; published results are held.
                acc_bits_d = '0;
                acc_pkts_d = '0;
            end else begin
                if (bits_ovf) sat_d = 1'b1;
                if (terminal) begin
                    // The terminal-cycle beat belongs to the closing window.
                    bitrate_d  = bits_new;
                    pkt_cnt_d  = pkts_new;
                    acc_bits_d = '0;
                    acc_pkts_d = '0;
                    if (bits_new > peak_q) peak_d = bits_new;
                end else begin
                    acc_bits_d = bits_new;
                    acc_pkts_d = pkts_new;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                acc_bits_q <= '0;
                acc_pkts_q <= '0;
                bitrate_q  <= '0;
                pkt_cnt_q  <= '0;
                peak_q     <= '0;
                sat_q      <= 1'b0;
            end else begin
                acc_bits_q <= acc_bits_d;
                acc_pkts_q <= acc_pkts_d;
                bitrate_q  <= bitrate_d;
                pkt_cnt_q  <= pkt_cnt_d;
                peak_q     <= peak_d;
                sat_q      <= sat_d;
            end
        end

        assign bitrate_out[ch*COUNTER_WIDTH +: COUNTER_WIDTH]   = bitrate_q;
        assign pkt_count_out[ch*COUNTER_WIDTH +: COUNTER_WIDTH] = pkt_cnt_q;
        assign peak_out[ch*COUNTER_WIDTH +: COUNTER_WIDTH]      = peak_q;
        assign sat_flag[ch]                                     = sat_q;
    end

endmodule

// File: tb/tb_axis_throughput_monitor.sv
// -----------------------------------------------------------------------------
// tb_axis_throughput_monitor
//
// Directed bench for axis_throughput_monitor. A 4-channel instance with the
// default widths carries the counting, window, clear, enable and reset cases;
// a 1-channel instance with 12-bit counters shares clock, enable and clear and
// carries the saturation case. Inputs change on the falling edge, outputs are
// sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_axis_throughput_monitor;

    localparam int NCH = 4;
    localparam int DW  = 256;
    localparam int KW  = DW / 8;
    localparam int CW  = 32;
    localparam int SCW = 12;
    localparam int W   = 200;

    logic clk = 1'b0;
    logic reset_n, enable, clear;

    logic [NCH-1:0]    tvalid, tready, tlast;
    logic [NCH*KW-1:0] tkeep;
    logic [NCH*CW-1:0] bitrate, pkt_count, peak;
    logic [NCH-1:0]    sat;
    logic              done;

    logic           s_valid, s_ready, s_last;
    logic [KW-1:0]  s_keep;
    logic [SCW-1:0] s_bitrate, s_pkt, s_peak;
    logic           s_sat, s_done;

    int vectors     = 0;
    int miscompares = 0;
    int dones, last_done;

    always #5 clk = ~clk;

    axis_throughput_monitor #(
        .NUM_CH(NCH), .DATA_WIDTH(DW), .COUNTER_WIDTH(CW), .WINDOW_CYCLES(W)
    ) u_dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear),
        .s_tvalid(tvalid), .s_tready(tready), .s_tkeep(tkeep), .s_tlast(tlast),
        .bitrate_out(bitrate), .pkt_count_out(pkt_count), .peak_out(peak),
        .sat_flag(sat), .window_done(done)
    );

    axis_throughput_monitor #(
        .NUM_CH(1), .DATA_WIDTH(DW), .COUNTER_WIDTH(SCW), .WINDOW_CYCLES(W)
    ) u_sat (
        .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear),
        .s_tvalid(s_valid), .s_tready(s_ready), .s_tkeep(s_keep), .s_tlast(s_last),
        .bitrate_out(s_bitrate), .pkt_count_out(s_pkt), .peak_out(s_peak),
        .sat_flag(s_sat), .window_done(s_done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ch_val(input logic [NCH*CW-1:0] bus, input int i);
        return 64'(bus[i*CW +: CW]);
    endfunction

    // Stimulus for cycle c of scenario t (0 = idle with enable low).
    task automatic drive_cycle(input int t, input int c);
        tvalid  = '0; tready = '0; tlast = '0; tkeep = '0;
        s_valid = 1'b0; s_ready = 1'b0; s_last = 1'b0; s_keep = '0;
        clear   = 1'b0;
        enable  = (t != 0) && (t != 9);
        case (t)
            1: begin  // full rate on ch0 and on the 12-bit instance
                tvalid[0] = 1'b1; tready[0] = 1'b1; tkeep[0 +: KW] = '1;
                s_valid = 1'b1; s_ready = 1'b1; s_keep = '1;
            end
            2: begin  // half the bytes, tready toggling 1/0
                tvalid[0] = 1'b1; tready[0] = (c % 2 == 0);
                tkeep[0 +: KW] = 32'h0000_FFFF;
            end
            4: begin  // channel i: (i+1)*10 full beats, tlast every 10th beat
                for (int i = 0; i < NCH; i++) begin
                    if (c < (i + 1) * 10) begin
                        tvalid[i] = 1'b1; tready[i] = 1'b1;
                        tkeep[i*KW +: KW] = '1; tlast[i] = (c % 10 == 9);
                    end
                end
            end
            5: begin
                tready[0] = 1'b1; tkeep[0 +: KW] = '1;  // tready without tvalid
                if (c == W - 1) begin                   // beat on terminal cycle
                    tvalid[1] = 1'b1; tready[1] = 1'b1; tkeep[KW +: KW] = '1; tlast[1] = 1'b1;
                end
                tvalid[2] = 1'b1; tkeep[2*KW +: KW] = '1; tlast[2] = 1'b1;  // no tready
                if (c == 50) begin                      // empty tkeep with tlast
                    tvalid[3] = 1'b1; tready[3] = 1'b1; tlast[3] = 1'b1;
                end
            end
            6: begin  // full rate, clear on the terminal cycle
                tvalid[0] = 1'b1; tready[0] = 1'b1; tkeep[0 +: KW] = '1;
                clear = (c == W - 1);
            end
            7: if (c == 0) begin tvalid[0] = 1'b1; tready[0] = 1'b1; tkeep[0 +: KW] = '1; end
            8, 9: begin  // partial window then disabled, traffic still present
                tvalid[0] = 1'b1; tready[0] = 1'b1; tkeep[0 +: KW] = '1;
            end
            10: if (c == 0) begin tvalid[0] = 1'b1; tready[0] = 1'b1; tkeep[0 +: KW] = 32'h1; end
            default: ;
        endcase
    endtask

    task automatic run(input int t, input int n, output int nd, output int last);
        nd = 0; last = -1;
        for (int c = 0; c < n; c++) begin
            drive_cycle(t, c);
            @(negedge clk);
            if (done) begin nd++; last = c; end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        drive_cycle(0, 0);
        repeat (3) @(negedge clk);
        for (int i = 0; i < NCH; i++) begin
            check($sformatf("reset_bitrate%0d", i), ch_val(bitrate, i), 0);
            check($sformatf("reset_peak%0d", i), ch_val(peak, i), 0);
        end
        check("reset_done", 64'(done), 0);
        check("reset_sat", 64'(sat), 0);
        reset_n = 1'b1;
        run(0, 4, dones, last_done);
        check("idle_disabled_dones", 64'(dones), 0);

        // Full-rate window on ch0, saturating window on the 12-bit instance
        run(1, W, dones, last_done);
        check("full_dones", 64'(dones), 1);
        check("full_done_cycle", 64'(last_done), W - 1);
        check("full_bitrate", ch_val(bitrate, 0), 51200);
        check("full_pkts", ch_val(pkt_count, 0), 0);
        check("full_peak", ch_val(peak, 0), 51200);
        check("full_ch1_quiet", ch_val(bitrate, 1), 0);
        check("sat_bitrate", 64'(s_bitrate), 4095);
        check("sat_flag_set", 64'(s_sat), 1);
        check("sat_peak", 64'(s_peak), 4095);

        run(2, W, dones, last_done);
        check("half_dones", 64'(dones), 1);
        check("half_bitrate", ch_val(bitrate, 0), 12800);
        check("half_peak_hold", ch_val(peak, 0), 51200);
        check("sat_idle_bitrate", 64'(s_bitrate), 0);
        check("sat_flag_sticky1", 64'(s_sat), 1);

        run(3, W, dones, last_done);
        check("idle_bitrate", ch_val(bitrate, 0), 0);
        check("idle_peak_hold", ch_val(peak, 0), 51200);
        check("sat_flag_sticky2", 64'(s_sat), 1);

        run(4, W, dones, last_done);
        check("multi_dones", 64'(dones), 1);
        for (int i = 0; i < NCH; i++) begin
            check($sformatf("multi_bitrate%0d", i), ch_val(bitrate, i), 64'((i + 1) * 2560));
            check($sformatf("multi_pkts%0d", i), ch_val(pkt_count, i), 64'(i + 1));
        end
        check("multi_peak0", ch_val(peak, 0), 51200);
        check("multi_peak3", ch_val(peak, 3), 10240);

        run(5, W, dones, last_done);
        check("edge_ready_only", ch_val(bitrate, 0), 0);
        check("edge_terminal_bits", ch_val(bitrate, 1), 256);
        check("edge_terminal_pkts", ch_val(pkt_count, 1), 1);
        check("edge_valid_only_bits", ch_val(bitrate, 2), 0);
        check("edge_valid_only_pkts", ch_val(pkt_count, 2), 0);
        check("edge_zero_keep_bits", ch_val(bitrate, 3), 0);
        check("edge_zero_keep_pkts", ch_val(pkt_count, 3), 1);
        check("edge_peak1_hold", ch_val(peak, 1), 5120);

        // clear on the terminal cycle
        run(6, W, dones, last_done);
        check("clear_no_done", 64'(dones), 0);
        check("clear_bitrate_hold", ch_val(bitrate, 1), 256);
        for (int i = 0; i < NCH; i++)
            check($sformatf("clear_peak%0d", i), ch_val(peak, i), 0);
        check("clear_sat", 64'(s_sat), 0);

        run(7, W, dones, last_done);
        check("postclr_done_cycle", 64'(last_done), W - 1);
        check("postclr_bitrate", ch_val(bitrate, 0), 256);
        check("postclr_peak", ch_val(peak, 0), 256);

        // enable dropped at cycle 150, then raised again
        run(8, 150, dones, last_done);
        check("partial_no_done", 64'(dones), 0);
        run(9, 10, dones, last_done);
        check("disabled_no_done", 64'(dones), 0);
        check("disabled_bitrate_hold", ch_val(bitrate, 0), 256);
        run(10, W, dones, last_done);
        check("reenable_dones", 64'(dones), 1);
        check("reenable_done_cycle", 64'(last_done), W - 1);
        check("reenable_bitrate", ch_val(bitrate, 0), 8);
        check("reenable_peak_hold", ch_val(peak, 0), 256);

        // reset_n pulsed mid-window, checked before the next clock edge
        run(4, 50, dones, last_done);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_bitrate", ch_val(bitrate, 0), 0);
        check("midrst_pkts", ch_val(pkt_count, 3), 0);
        check("midrst_peak", ch_val(peak, 0), 0);
        check("midrst_done", 64'(done), 0);
        @(negedge clk);
        drive_cycle(0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        run(0, 4, dones, last_done);
        run(1, W, dones, last_done);
        check("after_rst_done_cycle", 64'(last_done), W - 1);
        check("after_rst_bitrate", ch_val(bitrate, 0), 51200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axis_throughput_monitor.md
# axis_throughput_monitor

Passive, multi-channel AXI4-Stream throughput monitor and next-generation replacement for the single-channel DMA sniffer. It observes NUM_CH stream interfaces without driving them. Per channel, it counts transferred bits using tkeep byte qualifiers and packets using tlast over a programmable measurement window, and publishes registered per-window results with peak-hold and saturation flags. It sits beside the DMA datapath, and its outputs feed the status register block.

## Interface
- NUM_CH, 4, number of monitored stream channels (1–16)
- DATA_WIDTH, 256, tdata width per channel in bits; a multiple of 8
- COUNTER_WIDTH, 32, width of every bit, packet and peak counter
- WINDOW_CYCLES, 200, measurement window length in clk cycles (≥2); the default gives 1 µs at 200 MHz

- clk  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  high = measure; low = timer and accumulators held at 0
- clear  in  1  synchronous one-cycle clear of peaks, sticky flags and the window
- s_tvalid  in  NUM_CH  per-channel tvalid (bit i = channel i)
- s_tready  in  NUM_CH  per-channel tready, observed only
- s_tkeep  in  NUM_CH*DATA_WIDTH/8  per-channel tkeep; channel i occupies slice i*DATA_WIDTH/8 upward
- s_tlast  in  NUM_CH  per-channel tlast
- bitrate_out  out  NUM_CH*COUNTER_WIDTH  bits transferred in the last completed window, per channel
- pkt_count_out  out  NUM_CH*COUNTER_WIDTH  tlast beats in the last completed window, per channel
- peak_out  out  NUM_CH*COUNTER_WIDTH  maximum bitrate_out value since reset or clear, per channel
- sat_flag  out  NUM_CH  sticky; set when the channel's bit accumulator saturated
- window_done  out  1  one-cycle pulse when the outputs above update

## Operation
- Beat: a cycle in which s_tvalid[i] & s_tready[i] = 1. tvalid without tready, or tready without tvalid, counts nothing.
- Beat weight = 8 × popcount(tkeep slice). An all-zero tkeep adds 0 bits. If tlast is set on that beat, the packet counter still increments.
- Window timer: a 0..WINDOW_CYCLES-1 counter that advances every cycle while enable=1. The terminal cycle is timer = WINDOW_CYCLES-1.
- Accumulate: each cycle, acc_bits[i] += weight and acc_pkts[i] += tlast beat. Additions saturate at 2^COUNTER_WIDTH-1. A saturating bit add sets sat_flag[i].
- Terminal cycle:
  - Latch the result including the current beat: bitrate_out[i] = sat(acc_bits[i] + weight), pkt_count_out[i] = sat(acc_pkts[i] + tlast beat).
  - Reset the accumulators and the timer to 0.
  - If the new bitrate exceeds peak_out[i], load it into peak_out[i].
  - Drive window_done = 1.
- No state machine beyond the timer. Both channel-slice states, idle (enable=0) and measuring, are implied by enable.
- enable falling: the timer and accumulators clear on the next edge. A partial window is discarded, with no window_done. Results and peaks are held.
- clear: zeroes the timer, accumulators, peak_out and sat_flag on the next edge. bitrate_out and pkt_count_out hold.
- clear coincident with the terminal cycle: clear wins. There is no window_done and the outputs are not updated.
- Channels are fully independent. Only the timer is shared.

## Timing
- Reset: every output is 0, the timer is 0 and the accumulators are 0. Reset is asynchronous assert and synchronous release.
- All outputs are registered.
- window_done and the updated results appear together on the clk edge ending the terminal cycle.
- With enable held high from reset release, the first window_done occurs WINDOW_CYCLES cycles after the first enabled edge, then every WINDOW_CYCLES cycles.
- peak_out updates in the same cycle as bitrate_out.
- reset_n asserted mid-window: all state is lost immediately and the window restarts from 0 after release.

## Test plan
- NUM_CH=1, defaults, tvalid=tready=1, tkeep all-ones for 200 cycles from the window start → bitrate_out=51200, pkt_count_out=0, window_done once, peak_out=51200.
- Same stimulus with tkeep=0x0000FFFF and tready toggling 1/0 → bitrate_out=100×128=12800. Then a following idle window gives bitrate_out=0 while peak_out holds 51200.
- NUM_CH=4, each channel i sends (i+1)×10 full beats with tlast on every 10th beat → bitrate_out={2560, 5120, 7680, 10240} and pkt_count_out={1, 2, 3, 4}. Confirms there is no cross-channel leakage.
- COUNTER_WIDTH=12, full-rate traffic → bitrate_out=4095 and sat_flag=1 stays set across later idle windows until clear.
- A beat on the terminal cycle is counted in the closing window. clear asserted on a terminal cycle → no window_done, peak_out=0, next window starts from 0.
- enable dropped at cycle 150, then raised → no window_done for the partial window, and the next window_done arrives exactly 200 cycles after re-enable. reset_n pulsed mid-window → all outputs 0 immediately.
